// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Write-side scheduler for the async FIFO. NUM_REQ producers in the wr_clk
//   domain share one FIFO write port. Grants rotate round-robin. Each grant
//   covers a burst of up to BURST_LEN words. The FIFO full flag applies
//   backpressure. Each burst is preceded by exactly one arbitration cycle.
//
//   Optional feature (compile-time macro FIFO_WR_ARB_THROTTLE_EN):
//     While fifo_half_full is high, every burst is cut to a single word, so
//     the grant rotates after each transfer.
//
// Ports
//   wr_clk          write-domain clock
//   wr_rst_n        asynchronous active-low reset
//   req_valid       per-requester word valid
//   req_data        requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready       per-requester accept (combinational, only for the grant holder)
//   fifo_full       FIFO full flag, sampled combinationally
//   fifo_half_full  FIFO half-full flag (used only with the throttle macro)
//   fifo_wr_en      FIFO write enable (zero-latency from req_valid)
//   fifo_wr_data    FIFO write data, 0 when fifo_wr_en is low
//   grant_id        index of the current or most recent grant holder
//   busy            high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    parameter  int BURST_LEN  = 4,
    localparam int GW         = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_half_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        ARB,
        BURST
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   burst_cnt;

    logic            found;
    logic [GW-1:0]   winner;
    logic            grant_valid;
    logic [DATA_WIDTH-1:0] grant_data;
    logic            transfer;
    logic            last_word;

    // Round-robin search starting one past the previous winner, wrapping.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    // Select the grant holder's valid and data slice.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == i[GW-1:0]) begin
                grant_valid = req_valid[i];
                grant_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign transfer = (state == BURST) && grant_valid && !fifo_full;

`ifdef FIFO_WR_ARB_THROTTLE_EN
    // Half-full forces limit=1; any transfer while it is high ends the burst,
    // even when the flag rises partway through a longer burst.
    assign last_word = fifo_half_full || (burst_cnt == CW'(BURST_LEN - 1));
`else
    logic unused_half_full;
    assign unused_half_full = fifo_half_full;
    assign last_word = (burst_cnt == CW'(BURST_LEN - 1));
`endif

    // Zero-latency datapath: the grant holder's word goes straight to the FIFO.
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_id == i[GW-1:0]) begin
                    req_ready[i] = !fifo_full;
                end
            end
        end
    end

    assign fifo_wr_en   = transfer;
    assign fifo_wr_data = transfer ? grant_data : '0;
    assign busy         = (state == BURST);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= ARB;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (found) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        burst_cnt  <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (transfer) begin
                        if (last_word) begin
                            state <= ARB;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!grant_valid) begin
                        // Requester withdrew: abandon the burst.
                        state <= ARB;
                    end
                    // Otherwise stalled on fifo_full: hold everything.
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed self-checking bench for fifo_wr_arbiter (4 requesters, 32-bit
//   data, bursts of 4). Requesters are modelled as word counters. Each
//   requester emits {8'hA0, id, seq} words and advances when valid & ready.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          fifo_full;
    logic          fifo_half_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [1:0]    grant_id;
    logic          busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_LEN  (4)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst_n       (wr_rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_half_full (fifo_half_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;

    int cnt [NR];
    int seq [NR];

    logic          obs_en;
    logic [DW-1:0] obs_data;
    logic [NR-1:0] obs_ready;
    logic          obs_busy;
    logic [1:0]    obs_gid;

    function automatic logic [DW-1:0] mk(input int id, input int s);
        return {8'hA0, 8'(id), 16'(s)};
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = (cnt[i] > 0);
            req_data[i*DW +: DW]   = mk(i, seq[i]);
        end
    endtask

    // One cycle: sample outputs at negedge, advance requesters at posedge,
    // drive new inputs 1 time unit after the edge.
    task automatic step();
        @(negedge wr_clk);
        obs_en    = fifo_wr_en;
        obs_data  = fifo_wr_data;
        obs_ready = req_ready;
        obs_busy  = busy;
        obs_gid   = grant_id;
        @(posedge wr_clk);
        for (int i = 0; i < NR; i++) begin
            if (obs_ready[i] && req_valid[i]) begin
                cnt[i]--;
                seq[i]++;
            end
        end
        #1;
        drive();
    endtask

    task automatic do_reset();
        wr_rst_n       = 1'b0;
        fifo_full      = 1'b0;
        fifo_half_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0;
            seq[i] = 0;
        end
        drive();
        repeat (2) @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wr_rst_n       = 1'b0;
        fifo_full      = 1'b0;
        fifo_half_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0;
            seq[i] = 0;
        end
        drive();
        repeat (2) @(posedge wr_clk);
        #2;
        checks++;
        if ({req_ready, fifo_wr_en, busy, grant_id} !== 8'h00 || fifo_wr_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b en=%b busy=%b gid=%0d data=%h, required all 0",
                     req_ready, fifo_wr_en, busy, grant_id, fifo_wr_data);
        end
        #1;
        wr_rst_n = 1'b1;
        // No requests: stays idle.
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs_busy !== 1'b0 || obs_en !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_req c%0d: busy=%b en=%b, required 0 0", c, obs_busy, obs_en);
            end
        end
    endtask

    // 5 words from req0: bubble, 4 writes, bubble, 1 write, then abandon.
    task automatic test_single_req();
        logic [7:0] exp_en;
        logic [7:0] exp_busy;
        int e_seq;
        exp_en   = 8'b0101_1110;
        exp_busy = 8'b1101_1110;
        e_seq    = 0;
        do_reset();
        cnt[0] = 5;
        drive();
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (obs_en !== exp_en[c] || obs_busy !== exp_busy[c]) begin
                failures++;
                $display("FAIL single_en c%0d: en=%b busy=%b, required %b %b",
                         c, obs_en, obs_busy, exp_en[c], exp_busy[c]);
            end
            if (exp_en[c]) begin
                checks++;
                if (obs_data !== mk(0, e_seq) || obs_gid !== 2'd0) begin
                    failures++;
                    $display("FAIL single_data c%0d: data=%h gid=%0d, required %h 0",
                             c, obs_data, obs_gid, mk(0, e_seq));
                end
                e_seq++;
            end else begin
                checks++;
                if (obs_data !== '0) begin
                    failures++;
                    $display("FAIL single_data_zero c%0d: data=%h, required 0", c, obs_data);
                end
            end
        end
    endtask

    // All valid: grants 0,1,2,3,0 with 4 writes each and one bubble between.
    task automatic test_round_robin();
        int ph, b, g, s;
        do_reset();
        for (int i = 0; i < NR; i++) cnt[i] = 100;
        drive();
        for (int c = 0; c < 25; c++) begin
            step();
            ph = c % 5;
            b  = c / 5;
            g  = b % 4;
            s  = 4 * (b / 4) + ph - 1;
            if (ph == 0) begin
                checks++;
                if (obs_en !== 1'b0 || obs_busy !== 1'b0 || obs_ready !== 4'b0) begin
                    failures++;
                    $display("FAIL rr_bubble c%0d: en=%b busy=%b ready=%b, required 0 0 0000",
                             c, obs_en, obs_busy, obs_ready);
                end
            end else begin
                checks++;
                if (obs_en !== 1'b1 || obs_gid !== 2'(g) || obs_data !== mk(g, s) ||
                    obs_ready !== 4'(1 << g)) begin
                    failures++;
                    $display("FAIL rr_burst c%0d: en=%b gid=%0d data=%h ready=%b, required 1 %0d %h %b",
                             c, obs_en, obs_gid, obs_data, obs_ready, g, mk(g, s), 4'(1 << g));
                end
            end
        end
    endtask

    // req1 burst stalled by fifo_full for 3 cycles after its 2nd word.
    task automatic test_backpressure();
        logic [8:0] exp_en;
        int writes;
        int e_seq;
        exp_en = 9'b0_1100_0110;
        writes = 0;
        e_seq  = 0;
        do_reset();
        cnt[1] = 4;
        drive();
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            step();
            checks++;
            if (obs_en !== exp_en[c] || obs_ready !== (exp_en[c] ? 4'b0010 : 4'b0000)) begin
                failures++;
                $display("FAIL bp_en c%0d: en=%b ready=%b, required %b %b",
                         c, obs_en, obs_ready, exp_en[c], exp_en[c] ? 4'b0010 : 4'b0000);
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (obs_busy !== 1'b1 || obs_gid !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_hold c%0d: busy=%b gid=%0d, required 1 1", c, obs_busy, obs_gid);
                end
            end
            if (obs_en) begin
                checks++;
                if (obs_data !== mk(1, e_seq)) begin
                    failures++;
                    $display("FAIL bp_data c%0d: data=%h, required %h", c, obs_data, mk(1, e_seq));
                end
                e_seq++;
                writes++;
            end
        end
        fifo_full = 1'b0;
        checks++;
        if (writes !== 4 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_total: writes=%0d busy=%b, required 4 0", writes, obs_busy);
        end
    endtask

    // req2 withdraws after one word; req3 wins the next arbitration.
    task automatic test_abandon();
        do_reset();
        cnt[2] = 1;
        cnt[3] = 4;
        drive();
        step();
        step();
        checks++;
        if (obs_en !== 1'b1 || obs_gid !== 2'd2 || obs_data !== mk(2, 0)) begin
            failures++;
            $display("FAIL abandon_word: en=%b gid=%0d data=%h, required 1 2 %h",
                     obs_en, obs_gid, obs_data, mk(2, 0));
        end
        step();
        checks++;
        if (obs_en !== 1'b0 || obs_busy !== 1'b1) begin
            failures++;
            $display("FAIL abandon_drop: en=%b busy=%b, required 0 1", obs_en, obs_busy);
        end
        step();
        checks++;
        if (obs_busy !== 1'b0 || obs_en !== 1'b0) begin
            failures++;
            $display("FAIL abandon_arb: busy=%b en=%b, required 0 0", obs_busy, obs_en);
        end
        step();
        checks++;
        if (obs_gid !== 2'd3 || obs_en !== 1'b1 || obs_data !== mk(3, 0)) begin
            failures++;
            $display("FAIL abandon_next: gid=%0d en=%b data=%h, required 3 1 %h",
                     obs_gid, obs_en, obs_data, mk(3, 0));
        end
    endtask

    // Reset asserted mid-burst of req2; outputs drop at once, req0 first after.
    task automatic test_reset_mid_burst();
        do_reset();
        cnt[2] = 100;
        drive();
        repeat (3) step();
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || grant_id !== 2'd2) begin
            failures++;
            $display("FAIL rst_pre: en=%b gid=%0d, required 1 2", fifo_wr_en, grant_id);
        end
        wr_rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rst_async: en=%b ready=%b busy=%b gid=%0d, required 0 0000 0 0",
                     fifo_wr_en, req_ready, busy, grant_id);
        end
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 100;
            seq[i] = 0;
        end
        drive();
        repeat (2) @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
        step();
        checks++;
        if (obs_en !== 1'b0 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_bubble: en=%b busy=%b, required 0 0", obs_en, obs_busy);
        end
        step();
        checks++;
        if (obs_gid !== 2'd0 || obs_en !== 1'b1 || obs_data !== mk(0, 0)) begin
            failures++;
            $display("FAIL rst_first_grant: gid=%0d en=%b data=%h, required 0 1 %h",
                     obs_gid, obs_en, obs_data, mk(0, 0));
        end
    endtask

    // Half-full with all valid: 1 word per grant with the throttle macro,
    // full 4-word bursts without it.
    task automatic test_throttle();
        int ph, b, g, s, per;
`ifdef FIFO_WR_ARB_THROTTLE_EN
        per = 1;
`else
        per = 4;
`endif
        do_reset();
        fifo_half_full = 1'b1;
        for (int i = 0; i < NR; i++) cnt[i] = 100;
        drive();
        for (int c = 0; c < 4 * (per + 1); c++) begin
            step();
            ph = c % (per + 1);
            b  = c / (per + 1);
            g  = b % 4;
            s  = ph - 1;
            checks++;
            if (ph == 0) begin
                if (obs_en !== 1'b0 || obs_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL thr_bubble c%0d: en=%b busy=%b, required 0 0", c, obs_en, obs_busy);
                end
            end else if (obs_en !== 1'b1 || obs_gid !== 2'(g) || obs_data !== mk(g, s)) begin
                failures++;
                $display("FAIL thr_burst c%0d: en=%b gid=%0d data=%h, required 1 %0d %h",
                         c, obs_en, obs_gid, obs_data, g, mk(g, s));
            end
        end
        fifo_half_full = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_backpressure();
        test_abandon();
        test_reset_mid_burst();
        test_throttle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
